axi_adapter_2: RTL and testbench
================================

# axi_adapter_2

Bridge from the L1 cache subsystem's simple read/write request interface onto a 64-bit AXI4 master port (`ariane_axi::req_t` / `resp_t`). It issues single-beat or burst reads and writes. Read bursts are collected into a line buffer and returned as one response. Write responses are passed through.

## Interface
- `DATA_WORDS`, default 8: maximum burst length in 64-bit words. This is the line buffer size.
- `AXI_ID_WIDTH`, default 10: width of the AXI ID.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `rd_req_i` in 1: read request; held stable until granted.
- `rd_gnt_o` out 1: read request accepted (AR handshake).
- `rd_addr_i` in 64: read byte address.
- `rd_blen_i` in clog2(DATA_WORDS): number of beats minus 1.
- `rd_size_i` in 2: log2 of bytes per beat.
- `rd_id_i` in AXI_ID_WIDTH: transaction ID.
- `rd_rdy_i` in 1: consumer accepts the read response.
- `rd_valid_o` out 1: full read response available; registered.
- `rd_data_o` out DATA_WORDS×64: collected burst; word i = beat i.
- `rd_id_o` out AXI_ID_WIDTH: ID of the response.
- `rd_word_o` out 64: current R beat data.
- `rd_word_valid_o` out 1: R beat accepted this cycle.
- `rd_word_cnt_o` out clog2(DATA_WORDS): index of the current beat.
- `wr_req_i` in 1: write request; held stable until granted.
- `wr_gnt_o` out 1: write accepted (AW done and last W beat done).
- `wr_addr_i` in 64: write address.
- `wr_data_i` in DATA_WORDS×64: write data per beat.
- `wr_be_i` in DATA_WORDS×8: byte strobes per beat, already lane-aligned.
- `wr_blen_i` in clog2(DATA_WORDS): beats minus 1.
- `wr_size_i` in 2: log2 of bytes per beat.
- `wr_id_i` in AXI_ID_WIDTH: write ID.
- `wr_rdy_i` in 1: consumer accepts the write response.
- `wr_valid_o` out 1: write response (B) valid.
- `wr_id_o` out AXI_ID_WIDTH: B ID.
- `axi_req_o` out struct: AXI master request.
- `axi_resp_i` in struct: AXI slave response.

## Operation
- **AR channel**
  - `ar.valid` = `rd_req_i`, gated only by reset.
  - `ar.addr` = `rd_addr_i`; `len` = `rd_blen_i`; `size` = `{1'b0, rd_size_i}`; `burst` = INCR; `id` = `rd_id_i`.
  - `cache`, `prot`, `lock`, `qos`, `region` = 0.
  - `rd_gnt_o` = `ar.valid & ar_ready`, combinational.
- **R channel**
  - `r_ready` = !`rd_valid_o`.
  - On each accepted beat, write `r.data` into `rd_data_o[cnt]` and increment the 3-bit beat counter `cnt`.
  - On an accepted beat with `r.last`: set `rd_valid_o` = 1, capture `rd_id_o` = `r.id`, and clear `cnt`.
  - `rd_valid_o` clears in the cycle `rd_valid_o & rd_rdy_i`.
  - Buffer words beyond the burst length keep their old values.
  - Multiple outstanding reads are permitted at the AXI level; responses are returned in R order.
- **Write path** (states WR_IDLE, WR_BUSY)
  - In WR_IDLE with `wr_req_i`: assert `aw.valid` and `w.valid` in the same cycle, then go to WR_BUSY.
  - `aw` fields mirror the `ar` rules, using the `wr_*` inputs.
  - An `aw_done` flag sets on AW handshake; `aw.valid` then drops.
  - `w.data` = `wr_data_i[wcnt]`, `w.strb` = `wr_be_i[wcnt]`, `w.last` = (`wcnt` == `wr_blen_i`). `wcnt` increments on each W handshake.
  - Grant cycle: the first cycle where AW is done (or handshaking) and the last W beat handshakes (or has completed). `wr_gnt_o` pulses for exactly one cycle; the FSM returns to WR_IDLE and clears `aw_done`/`wcnt`.
  - AW may complete before, with, or after W; all orders must produce exactly one grant.
- **B channel**
  - `wr_valid_o` = `b.valid`; `wr_id_o` = `b.id`; `b_ready` = `wr_rdy_i`. All combinational.
- **Reset**
  - All registered outputs and state clear: `rd_valid_o` = 0, `rd_id_o` = 0, `rd_data_o` = 0, counters = 0, WR_IDLE.
  - While `rst_i` is high, all `valid`/`ready` outputs are 0.
  - Reset mid-burst aborts the transfer with no recovery.

## Timing
- Read grant latency: 0 cycles from `ar_ready`.
- `rd_valid_o` rises the cycle after the last R beat is accepted.
- Backpressure: while `rd_valid_o` is high, the R channel stalls.
- Write grant: same cycle as the completing handshake.
- B passthrough: 0 latency.

## Configuration
- `AXI_ADAPTER_RD_WORD_EN`
  - Defined: `rd_word_o` = `r.data`, `rd_word_valid_o` = `r.valid & r_ready`, `rd_word_cnt_o` = `cnt`.
  - Undefined: all three outputs are tied to 0.

## Test plan
- Single read, `blen`=0, `size`=3, `addr`=0x80000008, `id`=5; slave returns 0xDEAD with `last`.
  - Expect: `rd_gnt_o` for 1 cycle; next cycle `rd_valid_o`=1, `rd_data_o[0]`=0xDEAD, `rd_id_o`=5.
  - Held until `rd_rdy_i`.
- Read burst, `blen`=3; beats 0x10..0x13.
  - Expect: `rd_data_o[0..3]`=0x10..0x13; `rd_word_cnt_o` 0,1,2,3 (with the macro defined).
- Response backpressure: keep `rd_rdy_i`=0 for 4 cycles after `rd_valid_o`.
  - Expect: `r_ready`=0 throughout; next burst not accepted until release.
- Write, `blen`=0, `be`=0x0F; slave raises `aw_ready` 2 cycles after `w_ready`.
  - Expect: single `wr_gnt_o` in the AW handshake cycle; `w.last`=1.
- Write burst, `blen`=1, with `aw_ready` and `w_ready` both high.
  - Expect: beats 0 then 1, `last` on beat 1, `wr_gnt_o` in the second cycle.
  - Then B `id`=7 is passed through: `wr_valid_o`=1, `wr_id_o`=7.
- Assert `rst_i` during beat 2 of a 4-beat read.
  - Expect: `rd_valid_o`=0, `cnt`=0, and AR/AW/W valids all 0 the next cycle.

Source files
------------

// File: rtl/axi_adapter_2_if.sv
// rtl/axi_adapter_2_if.sv - 64-bit AXI4 master/slave bundle used by axi_adapter_2
interface axi_adapter_2_if #(
    parameter int ID_WIDTH = 10
);
    logic                aw_valid;
    logic                aw_ready;
    logic [63:0]         aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic [ID_WIDTH-1:0] aw_id;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic                aw_lock;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;

    logic                w_valid;
    logic                w_ready;
    logic [63:0]         w_data;
    logic [7:0]          w_strb;
    logic                w_last;

    logic                b_valid;
    logic                b_ready;
    logic [ID_WIDTH-1:0] b_id;

    logic                ar_valid;
    logic                ar_ready;
    logic [63:0]         ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic [ID_WIDTH-1:0] ar_id;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic                ar_lock;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;

    logic                r_valid;
    logic                r_ready;
    logic [63:0]         r_data;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_last;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
               aw_cache, aw_prot, aw_lock, aw_qos, aw_region,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id,
        output b_ready,
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
               ar_cache, ar_prot, ar_lock, ar_qos, ar_region,
        input  ar_ready,
        input  r_valid, r_data, r_id, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
               aw_cache, aw_prot, aw_lock, aw_qos, aw_region,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id,
        input  b_ready,
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
               ar_cache, ar_prot, ar_lock, ar_qos, ar_region,
        output ar_ready,
        output r_valid, r_data, r_id, r_last,
        input  r_ready
    );
endinterface

// File: rtl/axi_adapter_2.sv
// rtl/axi_adapter_2.sv - cache read/write requests onto a 64-bit AXI4 master; AXI_ADAPTER_RD_WORD_EN exposes per-beat read data
module axi_adapter_2 #(
    parameter  int DATA_WORDS   = 8,
    parameter  int AXI_ID_WIDTH = 10,
    localparam int CNT_W        = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,

    input  logic                             rd_req_i,
    output logic                             rd_gnt_o,
    input  logic [63:0]                      rd_addr_i,
    input  logic [CNT_W-1:0]                 rd_blen_i,
    input  logic [1:0]                       rd_size_i,
    input  logic [AXI_ID_WIDTH-1:0]          rd_id_i,
    input  logic                             rd_rdy_i,
    output logic                             rd_valid_o,
    output logic [DATA_WORDS-1:0][63:0]      rd_data_o,
    output logic [AXI_ID_WIDTH-1:0]          rd_id_o,
    output logic [63:0]                      rd_word_o,
    output logic                             rd_word_valid_o,
    output logic [CNT_W-1:0]                 rd_word_cnt_o,

    input  logic                             wr_req_i,
    output logic                             wr_gnt_o,
    input  logic [63:0]                      wr_addr_i,
    input  logic [DATA_WORDS-1:0][63:0]      wr_data_i,
    input  logic [DATA_WORDS-1:0][7:0]       wr_be_i,
    input  logic [CNT_W-1:0]                 wr_blen_i,
    input  logic [1:0]                       wr_size_i,
    input  logic [AXI_ID_WIDTH-1:0]          wr_id_i,
    input  logic                             wr_rdy_i,
    output logic                             wr_valid_o,
    output logic [AXI_ID_WIDTH-1:0]          wr_id_o,

    axi_adapter_2_if.master                  axi
);
    typedef enum logic {WR_IDLE, WR_BUSY} wr_state_t;

    wr_state_t        wr_state, wr_state_next;
    logic             aw_done, aw_done_next;
    logic             w_done, w_done_next;
    logic [CNT_W-1:0] wcnt, wcnt_next;
    logic [CNT_W-1:0] cnt;
    logic             aw_req, w_req, aw_hs, w_hs, w_last_beat, r_hs;

    // AR: pure passthrough of the request, gated only by reset
    assign axi.ar_valid  = rd_req_i & ~rst_i;
    assign axi.ar_addr   = rd_addr_i;
    assign axi.ar_len    = {{(8-CNT_W){1'b0}}, rd_blen_i};
    assign axi.ar_size   = {1'b0, rd_size_i};
    assign axi.ar_burst  = 2'b01;
    assign axi.ar_id     = rd_id_i;
    assign axi.ar_cache  = '0;
    assign axi.ar_prot   = '0;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_qos    = '0;
    assign axi.ar_region = '0;
    assign rd_gnt_o      = axi.ar_valid & axi.ar_ready;

    assign axi.r_ready = ~rd_valid_o & ~rst_i;
    assign r_hs        = axi.r_valid & axi.r_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_id_o    <= '0;
            rd_data_o  <= '0;
            cnt        <= '0;
        end else begin
            if (rd_valid_o && rd_rdy_i) begin
                rd_valid_o <= 1'b0;
            end
            if (r_hs) begin
                rd_data_o[cnt] <= axi.r_data;
                if (axi.r_last) begin
                    rd_valid_o <= 1'b1;
                    rd_id_o    <= axi.r_id;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef AXI_ADAPTER_RD_WORD_EN
    assign rd_word_o       = axi.r_data;
    assign rd_word_valid_o = r_hs;
    assign rd_word_cnt_o   = cnt;
`else
    assign rd_word_o       = '0;
    assign rd_word_valid_o = 1'b0;
    assign rd_word_cnt_o   = '0;
`endif

    // AW and W launch together; each then drops independently once its side is done
    assign aw_req      = ~rst_i & ((wr_state == WR_IDLE) ? wr_req_i : ~aw_done);
    assign w_req       = ~rst_i & ((wr_state == WR_IDLE) ? wr_req_i : ~w_done);
    assign aw_hs       = aw_req & axi.aw_ready;
    assign w_hs        = w_req & axi.w_ready;
    assign w_last_beat = (wcnt == wr_blen_i);

    assign axi.aw_valid  = aw_req;
    assign axi.aw_addr   = wr_addr_i;
    assign axi.aw_len    = {{(8-CNT_W){1'b0}}, wr_blen_i};
    assign axi.aw_size   = {1'b0, wr_size_i};
    assign axi.aw_burst  = 2'b01;
    assign axi.aw_id     = wr_id_i;
    assign axi.aw_cache  = '0;
    assign axi.aw_prot   = '0;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_qos    = '0;
    assign axi.aw_region = '0;

    assign axi.w_valid = w_req;
    assign axi.w_data  = wr_data_i[wcnt];
    assign axi.w_strb  = wr_be_i[wcnt];
    assign axi.w_last  = w_last_beat;

    always_comb begin
        wr_state_next = wr_state;
        aw_done_next  = aw_done;
        w_done_next   = w_done;
        wcnt_next     = wcnt;
        wr_gnt_o      = 1'b0;
        case (wr_state)
            WR_IDLE: if (wr_req_i) wr_state_next = WR_BUSY;
            WR_BUSY: wr_state_next = WR_BUSY;
            default: wr_state_next = WR_IDLE;
        endcase
        if (aw_hs) begin
            aw_done_next = 1'b1;
        end
        if (w_hs) begin
            if (w_last_beat) w_done_next = 1'b1;
            else             wcnt_next   = wcnt + 1'b1;
        end
        if ((aw_done | aw_hs) & (w_done | (w_hs & w_last_beat))) begin
            wr_gnt_o      = 1'b1;
            wr_state_next = WR_IDLE;
            aw_done_next  = 1'b0;
            w_done_next   = 1'b0;
            wcnt_next     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state <= WR_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wcnt     <= '0;
        end else begin
            wr_state <= wr_state_next;
            aw_done  <= aw_done_next;
            w_done   <= w_done_next;
            wcnt     <= wcnt_next;
        end
    end

    assign wr_valid_o  = axi.b_valid & ~rst_i;
    assign wr_id_o     = axi.b_id;
    assign axi.b_ready = wr_rdy_i & ~rst_i;
endmodule

// File: tb/tb_axi_adapter_2.sv
// tb/tb_axi_adapter_2.sv - directed self-checking bench for axi_adapter_2
module tb_axi_adapter_2;
    localparam int DW  = 8;
    localparam int IDW = 10;
`ifdef AXI_ADAPTER_RD_WORD_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 rd_req, rd_gnt, rd_rdy, rd_valid, rd_word_valid;
    logic [63:0]          rd_addr, rd_word;
    logic [2:0]           rd_blen, rd_word_cnt;
    logic [1:0]           rd_size;
    logic [IDW-1:0]       rd_id, rd_id_out;
    logic [DW-1:0][63:0]  rd_data;
    logic                 wr_req, wr_gnt, wr_rdy, wr_valid;
    logic [63:0]          wr_addr;
    logic [DW-1:0][63:0]  wr_data;
    logic [DW-1:0][7:0]   wr_be;
    logic [2:0]           wr_blen;
    logic [1:0]           wr_size;
    logic [IDW-1:0]       wr_id, wr_id_out;

    int checks = 0;
    int errors = 0;

    axi_adapter_2_if #(.ID_WIDTH(IDW)) axi ();

    axi_adapter_2 #(.DATA_WORDS(DW), .AXI_ID_WIDTH(IDW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_blen_i(rd_blen),
        .rd_size_i(rd_size), .rd_id_i(rd_id), .rd_rdy_i(rd_rdy), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .rd_id_o(rd_id_out), .rd_word_o(rd_word),
        .rd_word_valid_o(rd_word_valid), .rd_word_cnt_o(rd_word_cnt),
        .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_be_i(wr_be), .wr_blen_i(wr_blen), .wr_size_i(wr_size), .wr_id_i(wr_id),
        .wr_rdy_i(wr_rdy), .wr_valid_o(wr_valid), .wr_id_o(wr_id_out),
        .axi(axi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_rdy = 1'b0; wr_rdy = 1'b0;
        rd_addr = '0; rd_blen = '0; rd_size = '0; rd_id = '0;
        wr_addr = '0; wr_data = '0; wr_be = '0; wr_blen = '0; wr_size = '0; wr_id = '0;
        axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_id = '0; axi.r_last = 1'b0;
        axi.b_valid = 1'b0; axi.b_id = '0;

        // reset: valids gated even with requests pending
        tick(); settle();
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_aw_valid", axi.aw_valid, 0);
        chk("rst_w_valid", axi.w_valid, 0);
        chk("rst_r_ready", axi.r_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        tick();
        rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        settle();
        chk("post_rst_rd_valid", rd_valid, 0);
        chk("post_rst_rd_id", rd_id_out, 0);
        chk("post_rst_rd_data0", rd_data[0], 0);
        chk("post_rst_r_ready", axi.r_ready, 1);
        chk("post_rst_wr_gnt", wr_gnt, 0);

        // single read
        tick();
        rd_req = 1'b1; rd_addr = 64'h8000_0008; rd_blen = 3'd0; rd_size = 2'd3; rd_id = 10'd5;
        axi.ar_ready = 1'b1;
        settle();
        chk("t1_rd_gnt", rd_gnt, 1);
        chk("t1_ar_addr", axi.ar_addr, 64'h8000_0008);
        chk("t1_ar_len", axi.ar_len, 0);
        chk("t1_ar_size", axi.ar_size, 3);
        chk("t1_ar_burst", axi.ar_burst, 1);
        chk("t1_ar_id", axi.ar_id, 5);
        tick();
        rd_req = 1'b0; axi.ar_ready = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'hDEAD; axi.r_last = 1'b1; axi.r_id = 10'd5;
        settle();
        chk("t1_gnt_drop", rd_gnt, 0);
        chk("t1_r_ready", axi.r_ready, 1);
        chk("t1_valid_not_yet", rd_valid, 0);
        tick();
        axi.r_valid = 1'b0;
        settle();
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data0", rd_data[0], 64'hDEAD);
        chk("t1_rd_id", rd_id_out, 5);
        tick(); settle();
        chk("t1_held", rd_valid, 1);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        settle();
        chk("t1_released", rd_valid, 0);

        // read burst of 4
        rd_req = 1'b1; rd_addr = 64'h1000; rd_blen = 3'd3; rd_id = 10'd3; axi.ar_ready = 1'b1;
        settle();
        chk("t2_rd_gnt", rd_gnt, 1);
        chk("t2_ar_len", axi.ar_len, 3);
        tick();
        rd_req = 1'b0; axi.ar_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi.r_valid = 1'b1; axi.r_data = 64'h10 + 64'(i); axi.r_last = (i == 3); axi.r_id = 10'd3;
            settle();
            chk("t2_word_cnt", rd_word_cnt, WORD_EN ? 64'(i) : 64'd0);
            chk("t2_word_valid", rd_word_valid, WORD_EN ? 64'd1 : 64'd0);
            chk("t2_word", rd_word, WORD_EN ? 64'h10 + 64'(i) : 64'd0);
            tick();
        end
        axi.r_valid = 1'b0; axi.r_last = 1'b0;
        settle();
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_d0", rd_data[0], 64'h10);
        chk("t2_d1", rd_data[1], 64'h11);
        chk("t2_d2", rd_data[2], 64'h12);
        chk("t2_d3", rd_data[3], 64'h13);
        chk("t2_d4_untouched", rd_data[4], 0);
        chk("t2_rd_id", rd_id_out, 3);

        // response backpressure stalls R
        tick();
        axi.r_valid = 1'b1; axi.r_data = 64'h55; axi.r_last = 1'b1; axi.r_id = 10'd4;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_r_ready_low", axi.r_ready, 0);
            chk("t3_rd_valid_hold", rd_valid, 1);
            tick();
        end
        chk("t3_d0_kept", rd_data[0], 64'h10);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        settle();
        chk("t3_cleared", rd_valid, 0);
        chk("t3_r_ready_back", axi.r_ready, 1);
        tick();
        axi.r_valid = 1'b0; axi.r_last = 1'b0;
        settle();
        chk("t3_rd_valid", rd_valid, 1);
        chk("t3_d0", rd_data[0], 64'h55);
        chk("t3_d1_kept", rd_data[1], 64'h11);
        chk("t3_rd_id", rd_id_out, 4);
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;

        // single write, W before AW
        wr_req = 1'b1; wr_addr = 64'h2000; wr_data[0] = 64'hCAFE; wr_be[0] = 8'h0F;
        wr_blen = 3'd0; wr_size = 2'd3; wr_id = 10'd2; axi.w_ready = 1'b1; axi.aw_ready = 1'b0;
        settle();
        chk("t4_aw_valid", axi.aw_valid, 1);
        chk("t4_w_valid", axi.w_valid, 1);
        chk("t4_w_last", axi.w_last, 1);
        chk("t4_w_strb", axi.w_strb, 8'h0F);
        chk("t4_w_data", axi.w_data, 64'hCAFE);
        chk("t4_gnt_early", wr_gnt, 0);
        tick(); settle();
        chk("t4_w_valid_drop", axi.w_valid, 0);
        chk("t4_aw_still", axi.aw_valid, 1);
        chk("t4_gnt_wait", wr_gnt, 0);
        tick();
        axi.aw_ready = 1'b1;
        settle();
        chk("t4_gnt", wr_gnt, 1);
        tick();
        wr_req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        settle();
        chk("t4_gnt_once", wr_gnt, 0);
        chk("t4_aw_idle", axi.aw_valid, 0);

        // write burst of 2, both ready, then B passthrough
        wr_req = 1'b1; wr_blen = 3'd1; wr_data[0] = 64'hA0; wr_data[1] = 64'hA1;
        wr_be[0] = 8'hFF; wr_be[1] = 8'hFF; axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
        settle();
        chk("t5_b0_data", axi.w_data, 64'hA0);
        chk("t5_b0_last", axi.w_last, 0);
        chk("t5_b0_gnt", wr_gnt, 0);
        tick(); settle();
        chk("t5_aw_drop", axi.aw_valid, 0);
        chk("t5_b1_data", axi.w_data, 64'hA1);
        chk("t5_b1_last", axi.w_last, 1);
        chk("t5_gnt", wr_gnt, 1);
        tick();
        wr_req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        axi.b_valid = 1'b1; axi.b_id = 10'd7; wr_rdy = 1'b1;
        settle();
        chk("t5_gnt_once", wr_gnt, 0);
        chk("t5_wr_valid", wr_valid, 1);
        chk("t5_wr_id", wr_id_out, 7);
        chk("t5_b_ready", axi.b_ready, 1);
        tick();
        axi.b_valid = 1'b0; wr_rdy = 1'b0;

        // reset during beat 2 of a 4-beat read, with a write in flight
        rd_req = 1'b1; rd_addr = 64'h100; rd_blen = 3'd3; rd_id = 10'd1; axi.ar_ready = 1'b1;
        wr_req = 1'b1; wr_blen = 3'd1; wr_data[0] = 64'hB0; wr_data[1] = 64'hB1; axi.w_ready = 1'b1;
        settle();
        chk("t6_rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 1'b0; axi.ar_ready = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'h20; axi.r_last = 1'b0; axi.r_id = 10'd1;
        settle();
        chk("t6_wcnt_adv", axi.w_data, 64'hB1);
        tick();
        axi.r_data = 64'h21;
        tick();
        axi.r_data = 64'h22; rst = 1'b1; rd_req = 1'b1;
        tick(); settle();
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_ar_valid", axi.ar_valid, 0);
        chk("t6_aw_valid", axi.aw_valid, 0);
        chk("t6_w_valid", axi.w_valid, 0);
        chk("t6_r_ready", axi.r_ready, 0);
        chk("t6_d1_cleared", rd_data[1], 0);
        chk("t6_word_cnt", rd_word_cnt, 0);
        tick();
        rst = 1'b0; rd_req = 1'b0; axi.r_valid = 1'b0; axi.w_ready = 1'b0;
        settle();
        chk("t6_wcnt_cleared", axi.w_data, 64'hB0);
        chk("t6_aw_relaunch", axi.aw_valid, 1);
        wr_req = 1'b0;
        rd_req = 1'b1; rd_blen = 3'd0; rd_id = 10'd9; axi.ar_ready = 1'b1;
        settle();
        chk("t6_rd_gnt2", rd_gnt, 1);
        tick();
        rd_req = 1'b0; axi.ar_ready = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'h77; axi.r_last = 1'b1; axi.r_id = 10'd9;
        tick();
        axi.r_valid = 1'b0; axi.r_last = 1'b0;
        settle();
        chk("t6_rd_valid2", rd_valid, 1);
        chk("t6_d0_cnt_zero", rd_data[0], 64'h77);
        chk("t6_d1_still_zero", rd_data[1], 0);
        chk("t6_rd_id2", rd_id_out, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
